// File: rtl/clk_div_multi_pkg.sv
// Shared constants for the multi-channel clock divider (see clk_div_multi for CLKDIV_SYNC_EN).
package clk_div_multi_pkg;

    localparam int unsigned CLK_DIV_CNT_W   = 32;
    localparam int unsigned CLK_DIV_MAX_CH  = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 250000;

endpackage : clk_div_multi_pkg

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active/pending divisor, level and strobes.
// Divisor changes are only taken at half-period boundaries or while idle, so no runt pulses.
module clk_div_ch
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned CNT_W       = CLK_DIV_CNT_W,
    parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             rise_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] load_div_c;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             rise_q, rise_d;

    // Next-state: a same-cycle write overrides the pending value wherever it is consumed.
    always_comb begin
        load_div_c = wr_i ? wr_div_i : pending_q;
        pending_d  = load_div_c;
        cnt_d      = cnt_q + CNT_W'(1);
        active_d   = active_q;
        out_d      = out_q;
        tick_d     = 1'b0;
        rise_d     = 1'b0;
        if (!en_i || sync_i) begin
            cnt_d    = '0;
            out_d    = 1'b0;
            active_d = load_div_c;
        end else if (cnt_q == active_q) begin
            cnt_d    = '0;
            out_d    = ~out_q;
            tick_d   = 1'b1;
            rise_d   = ~out_q;
            active_d = load_div_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            active_q  <= CNT_W'(DEFAULT_DIV);
            pending_q <= CNT_W'(DEFAULT_DIV);
            out_q     <= 1'b0;
            tick_q    <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
            rise_q    <= rise_d;
        end
    end

    assign clk_out_o = out_q;
    assign tick_o    = tick_q;
    assign rise_o    = rise_q;

endmodule : clk_div_ch

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; all outputs are clk-synchronous levels/strobes.
// Define CLKDIV_SYNC_EN to add the sync_restart input that phase-aligns all enabled channels.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned CNT_W       = CLK_DIV_CNT_W,
    parameter  int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_restart,
`endif
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] rise
);

    logic              sync_c;
    logic [NUM_CH-1:0] wr_c;

`ifdef CLKDIV_SYNC_EN
    assign sync_c = sync_restart;
`else
    assign sync_c = 1'b0;
`endif

    // Channel numbers at or beyond NUM_CH match no decoder and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_c[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sync_i    (sync_c),
            .en_i      (ch_en[i]),
            .wr_i      (wr_c[i]),
            .wr_div_i  (cfg_div),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i]),
            .rise_o    (rise[i])
        );
    end

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi against a boundary-schedule reference model.
module tb_clk_div_multi;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 32;
    localparam int unsigned DEF = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic           sync_restart;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] clk_out, tick, rise;

    int checks   = 0;
    int failures = 0;
    int unsigned edge_n = 0;

    // Model: absolute edge index of each channel's next boundary, plus expected outputs.
    int unsigned    m_pend [NCH];
    int unsigned    m_nxt  [NCH];
    logic [NCH-1:0] m_out, m_tick, m_rise;

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef CLKDIV_SYNC_EN
        .sync_restart (sync_restart),
`endif
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .ch_en        (ch_en),
        .clk_out      (clk_out),
        .tick         (tick),
        .rise         (rise)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        edge_n++;
        for (int c = 0; c < int'(NCH); c++) begin
            logic        wr;
            int unsigned ld;
            wr = cfg_we && (int'(cfg_ch) == c);
            ld = wr ? cfg_div : m_pend[c];
            if (rst) begin
                m_pend[c] = DEF;
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
                m_rise[c] = 1'b0;
                m_nxt[c]  = edge_n + 1 + DEF;
            end else begin
                m_pend[c] = ld;
                if (!ch_en[c] || sync_restart) begin
                    m_out[c]  = 1'b0;
                    m_tick[c] = 1'b0;
                    m_rise[c] = 1'b0;
                    m_nxt[c]  = edge_n + 1 + ld;
                end else if (edge_n == m_nxt[c]) begin
                    m_out[c]  = ~m_out[c];
                    m_tick[c] = 1'b1;
                    m_rise[c] = m_out[c];
                    m_nxt[c]  = edge_n + 1 + ld;
                end else begin
                    m_tick[c] = 1'b0;
                    m_rise[c] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 7; ch_en = '1;
        step();
        checks++;
        if ({clk_out, tick, rise} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0", {clk_out, tick, rise});
        end
        rst = 1'b0; cfg_we = 1'b0; ch_en = '0;
        step();
        ch_en = 3'b001;
        for (int k = 0; k <= int'(DEF) + 1; k++) begin
            step();
            checks++;
            if (tick[0] !== (k == int'(DEF))) begin
                failures++;
                $display("FAIL reset_default_div k=%0d: tick0=%b required %b", k, tick[0], k == int'(DEF));
            end
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL reset_model k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
        ch_en = '0;
        step();
    endtask

    task automatic test_div3();
        logic eo, et, er;
        int   nb;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 3;
        step();
        cfg_we = 1'b0; ch_en[0] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            nb = (k >= 3) ? ((k - 3) / 4 + 1) : 0;
            eo = (nb % 2) == 1;
            et = (k % 4) == 3;
            er = (k % 8) == 3;
            checks++;
            if ({clk_out[0], tick[0], rise[0]} !== {eo, et, er}) begin
                failures++;
                $display("FAIL div3 k=%0d: out/tick/rise=%b required %b", k, {clk_out[0], tick[0], rise[0]}, {eo, et, er});
            end
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL div3_model k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
    endtask

    task automatic test_div0();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 0;
        step();
        cfg_we = 1'b0; ch_en[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if ({clk_out[1], tick[1], rise[1]} !== {k % 2 == 0, 1'b1, k % 2 == 0}) begin
                failures++;
                $display("FAIL div0 k=%0d: out/tick/rise=%b required %b", k, {clk_out[1], tick[1], rise[1]}, {k % 2 == 0, 1'b1, k % 2 == 0});
            end
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL div0_model k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
        ch_en[1] = 1'b0;
        step();
    endtask

    task automatic test_reprogram();
        int n;
        for (n = 0; n < 20 && !tick[0]; n++) step();
        checks++;
        if (!tick[0]) begin
            failures++;
            $display("FAIL reprog_wait: tick0 not seen in %0d cycles, required within 20", n);
        end
        step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 1;
        step();
        cfg_we = 1'b0;
        for (int t = 3; t <= 10; t++) begin
            step();
            checks++;
            if (tick[0] !== (t >= 4 && t % 2 == 0)) begin
                failures++;
                $display("FAIL reprog_tick t=%0d: tick0=%b required %b", t, tick[0], t >= 4 && t % 2 == 0);
            end
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL reprog_model t=%0d: got %b required %b", t, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
    endtask

    task automatic test_disable();
        int n;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 2;
        step();
        cfg_we = 1'b0; ch_en[2] = 1'b1;
        for (n = 0; n < 20 && !clk_out[2]; n++) step();
        checks++;
        if (!clk_out[2]) begin
            failures++;
            $display("FAIL disable_wait: clk_out2 low after %0d cycles, required high within 20", n);
        end
        ch_en[2] = 1'b0;
        step();
        checks++;
        if ({clk_out[2], tick[2], rise[2]} !== 3'b000) begin
            failures++;
            $display("FAIL disable_clear: out/tick/rise=%b required 000", {clk_out[2], tick[2], rise[2]});
        end
        step();
        ch_en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({clk_out[2], rise[2]} !== {k == 2, k == 2}) begin
                failures++;
                $display("FAIL reenable k=%0d: out/rise=%b required %b", k, {clk_out[2], rise[2]}, {k == 2, k == 2});
            end
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL reenable_model k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
    endtask

    task automatic test_bad_ch_and_reset();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 9;
        step();
        cfg_we = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL bad_ch_model k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({clk_out, tick, rise} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b required 0", {clk_out, tick, rise});
        end
        ch_en = '1;
        for (int k = 0; k <= int'(DEF) + 2; k++) begin
            step();
            checks++;
            if (tick !== {NCH{k == int'(DEF)}}) begin
                failures++;
                $display("FAIL midreset_default k=%0d: tick=%b required %b", k, tick, {NCH{k == int'(DEF)}});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            rst     = ($urandom_range(0, 199) == 0);
            cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_div = CW'($urandom_range(0, 6));
            for (int c = 0; c < int'(NCH); c++)
                if ($urandom_range(0, 39) == 0) ch_en[c] = ~ch_en[c];
`ifdef CLKDIV_SYNC_EN
            sync_restart = ($urandom_range(0, 49) == 0);
`endif
            step();
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL random k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
        rst = 1'b0; cfg_we = 1'b0; sync_restart = 1'b0;
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync_restart();
        ch_en = 3'b011;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 2;
        step();
        cfg_ch = 2'd1; cfg_div = 4;
        step();
        cfg_we = 1'b0;
        repeat (7 + $urandom_range(0, 9)) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        checks++;
        if (clk_out[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL sync_clear: clk_out=%b required 00", clk_out[1:0]);
        end
        for (int k = 0; k < 17; k++) begin
            step();
            checks++;
            if (rise[1:0] !== {k == 4 || k == 14, k == 2 || k == 8 || k == 14}) begin
                failures++;
                $display("FAIL sync_rise k=%0d: rise=%b required %b", k, rise[1:0], {k == 4 || k == 14, k == 2 || k == 8 || k == 14});
            end
            checks++;
            if ({clk_out, tick, rise} !== {m_out, m_tick, m_rise}) begin
                failures++;
                $display("FAIL sync_model k=%0d: got %b required %b", k, {clk_out, tick, rise}, {m_out, m_tick, m_rise});
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; sync_restart = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = '0;
        m_out = '0; m_tick = '0; m_rise = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            m_pend[c] = DEF;
            m_nxt[c]  = 0;
        end
        #1;
        test_reset();
        test_div3();
        test_div0();
        test_reprogram();
        test_disable();
        test_bad_ch_and_reset();
`ifdef CLKDIV_SYNC_EN
        test_sync_restart();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_div_multi
